// File: rtl/mem_pattern_checker.sv
// rtl/mem_pattern_checker.sv - memory self-test master: pattern write, readback compare, timeout
//
// Writes pat(a) to addresses 0..DEPTH-1, then reads every address back and compares.
// Ports:
//   clk_i, rst_i                     clock, asynchronous active-high reset
//   start_i, pattern_sel_i, seed_i   test launch and pattern selection (latched at start)
//   busy_o, done_o, pass_o, timeout_o         run status
//   err_cnt_o, first_err_addr_o, first_err_data_o  mismatch statistics
//   mem_valid_o, mem_wr_rd_o, mem_addr_o, mem_wr_data_o  request port to memory
//   mem_ready_i, mem_rd_data_i       registered one-cycle memory response
module mem_pattern_checker #(
    parameter int WIDTH      = 16,
    parameter int DEPTH      = 16,
    parameter int ADDR_LINES = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [1:0]            pattern_sel_i,
    input  logic [WIDTH-1:0]      seed_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  pass_o,
    output logic                  timeout_o,
    output logic [ADDR_LINES:0]   err_cnt_o,
    output logic [ADDR_LINES-1:0] first_err_addr_o,
    output logic [WIDTH-1:0]      first_err_data_o,
    output logic                  mem_valid_o,
    output logic                  mem_wr_rd_o,
    output logic [ADDR_LINES-1:0] mem_addr_o,
    output logic [WIDTH-1:0]      mem_wr_data_o,
    input  logic                  mem_ready_i,
    input  logic [WIDTH-1:0]      mem_rd_data_i
);

    localparam int TO_W  = $clog2(TIMEOUT + 1);
    localparam int ERR_W = ADDR_LINES + 1;
    localparam logic [ADDR_LINES-1:0] LAST_ADDR = ADDR_LINES'(DEPTH - 1);
    localparam logic [ERR_W-1:0]      ERR_MAX   = ERR_W'(DEPTH);
    localparam logic [TO_W-1:0]       TO_LIMIT  = TO_W'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE, S_WR_REQ, S_WR_WAIT, S_RD_REQ, S_RD_WAIT, S_DONE
    } state_t;

    function automatic logic [WIDTH-1:0] pat_f(input logic [1:0] sel,
                                               input logic [WIDTH-1:0] seed,
                                               input logic [ADDR_LINES-1:0] a);
        logic [WIDTH-1:0] a_ext;
        a_ext = WIDTH'(a);
        case (sel)
            2'd0:    return a_ext;
            2'd1:    return seed;
            2'd2:    return seed ^ a_ext;
            default: return a[0] ? ~seed : seed;
        endcase
    endfunction

    state_t                  state_q;
    logic [ADDR_LINES-1:0]   addr_q;
    logic [TO_W-1:0]         to_cnt_q;
    logic [1:0]              sel_q;
    logic [WIDTH-1:0]        seed_q;
    logic                    busy_q, done_q, pass_q, timeout_q;
    logic [ERR_W-1:0]        err_cnt_q;
    logic [ADDR_LINES-1:0]   ferr_addr_q;
    logic [WIDTH-1:0]        ferr_data_q;
    logic                    mem_valid_q, mem_wr_rd_q;
    logic [WIDTH-1:0]        mem_wr_data_q;

    logic [ADDR_LINES-1:0]   addr_inc_d;
    logic [TO_W-1:0]         to_cnt_d;
    logic                    rd_mismatch_d;
    logic [ERR_W-1:0]        err_cnt_d;

    assign addr_inc_d    = addr_q + ADDR_LINES'(1);
    assign to_cnt_d      = to_cnt_q + TO_W'(1);
    assign rd_mismatch_d = (mem_rd_data_i != pat_f(sel_q, seed_q, addr_q));
    assign err_cnt_d     = (rd_mismatch_d && (err_cnt_q != ERR_MAX)) ? err_cnt_q + ERR_W'(1)
                                                                     : err_cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= S_IDLE;
            addr_q        <= '0;
            to_cnt_q      <= '0;
            sel_q         <= '0;
            seed_q        <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            timeout_q     <= 1'b0;
            err_cnt_q     <= '0;
            ferr_addr_q   <= '0;
            ferr_data_q   <= '0;
            mem_valid_q   <= 1'b0;
            mem_wr_rd_q   <= 1'b0;
            mem_wr_data_q <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    mem_valid_q <= 1'b0;
                    if (start_i) begin
                        sel_q         <= pattern_sel_i;
                        seed_q        <= seed_i;
                        done_q        <= 1'b0;
                        pass_q        <= 1'b0;
                        timeout_q     <= 1'b0;
                        err_cnt_q     <= '0;
                        ferr_addr_q   <= '0;
                        ferr_data_q   <= '0;
                        addr_q        <= '0;
                        busy_q        <= 1'b1;
                        // Request outputs are registered, so the first write is
                        // presented in the same cycle the FSM enters WR_REQ.
                        mem_valid_q   <= 1'b1;
                        mem_wr_rd_q   <= 1'b1;
                        mem_wr_data_q <= pat_f(pattern_sel_i, seed_i, '0);
                        state_q       <= S_WR_REQ;
                    end
                end
                S_WR_REQ: begin
                    mem_valid_q <= 1'b0;
                    to_cnt_q    <= '0;
                    state_q     <= S_WR_WAIT;
                end
                S_WR_WAIT: begin
                    if (mem_ready_i) begin
                        mem_valid_q <= 1'b1;
                        if (addr_q == LAST_ADDR) begin
                            addr_q      <= '0;
                            mem_wr_rd_q <= 1'b0;
                            state_q     <= S_RD_REQ;
                        end else begin
                            addr_q        <= addr_inc_d;
                            mem_wr_data_q <= pat_f(sel_q, seed_q, addr_inc_d);
                            state_q       <= S_WR_REQ;
                        end
                    end else if (to_cnt_d == TO_LIMIT) begin
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        pass_q    <= 1'b0;
                        timeout_q <= 1'b1;
                        state_q   <= S_DONE;
                    end else begin
                        to_cnt_q <= to_cnt_d;
                    end
                end
                S_RD_REQ: begin
                    mem_valid_q <= 1'b0;
                    to_cnt_q    <= '0;
                    state_q     <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    if (mem_ready_i) begin
                        err_cnt_q <= err_cnt_d;
                        // A zero count before this read marks the first mismatch.
                        if (rd_mismatch_d && (err_cnt_q == '0)) begin
                            ferr_addr_q <= addr_q;
                            ferr_data_q <= mem_rd_data_i;
                        end
                        if (addr_q == LAST_ADDR) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (err_cnt_d == '0);
                            state_q <= S_DONE;
                        end else begin
                            addr_q      <= addr_inc_d;
                            mem_valid_q <= 1'b1;
                            mem_wr_rd_q <= 1'b0;
                            state_q     <= S_RD_REQ;
                        end
                    end else if (to_cnt_d == TO_LIMIT) begin
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        pass_q    <= 1'b0;
                        timeout_q <= 1'b1;
                        state_q   <= S_DONE;
                    end else begin
                        to_cnt_q <= to_cnt_d;
                    end
                end
                default: begin
                    mem_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign pass_o           = pass_q;
    assign timeout_o        = timeout_q;
    assign err_cnt_o        = err_cnt_q;
    assign first_err_addr_o = ferr_addr_q;
    assign first_err_data_o = ferr_data_q;
    assign mem_valid_o      = mem_valid_q;
    assign mem_wr_rd_o      = mem_wr_rd_q;
    assign mem_addr_o       = addr_q;
    assign mem_wr_data_o    = mem_wr_data_q;

endmodule

// File: tb/tb_mem_pattern_checker.sv
// tb/tb_mem_pattern_checker.sv - self-checking bench for mem_pattern_checker
module tb_mem_pattern_checker;

    localparam int DEPTH = 16;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic [1:0]  pattern_sel_i = 2'd0;
    logic [15:0] seed_i = 16'h0;
    logic        busy_o, done_o, pass_o, timeout_o;
    logic [4:0]  err_cnt_o;
    logic [3:0]  first_err_addr_o;
    logic [15:0] first_err_data_o;
    logic        mem_valid_o, mem_wr_rd_o;
    logic [3:0]  mem_addr_o;
    logic [15:0] mem_wr_data_o;
    logic        mem_ready_i = 1'b0;
    logic [15:0] mem_rd_data_i = 16'h0;

    mem_pattern_checker #(.WIDTH(16), .DEPTH(16), .ADDR_LINES(4), .TIMEOUT(15)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .pattern_sel_i(pattern_sel_i),
        .seed_i(seed_i), .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o),
        .timeout_o(timeout_o), .err_cnt_o(err_cnt_o), .first_err_addr_o(first_err_addr_o),
        .first_err_data_o(first_err_data_o), .mem_valid_o(mem_valid_o),
        .mem_wr_rd_o(mem_wr_rd_o), .mem_addr_o(mem_addr_o), .mem_wr_data_o(mem_wr_data_o),
        .mem_ready_i(mem_ready_i), .mem_rd_data_i(mem_rd_data_i)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Memory model: registered one-cycle response, optional read bit-0 faults
    // and optional withheld ready on the write to hold_addr.
    logic [15:0] mem_arr [DEPTH];
    logic [15:0] fault_mask = 16'h0;
    logic        hold_en = 1'b0;
    localparam logic [3:0] HOLD_ADDR = 4'd3;

    always @(posedge clk_i) begin
        mem_ready_i <= 1'b0;
        if (mem_valid_o) begin
            if (!(hold_en && mem_wr_rd_o && mem_addr_o == HOLD_ADDR))
                mem_ready_i <= 1'b1;
            if (mem_wr_rd_o)
                mem_arr[mem_addr_o] <= mem_wr_data_o;
            else
                mem_rd_data_i <= mem_arr[mem_addr_o] ^ {15'h0, fault_mask[mem_addr_o]};
        end
    end

    function automatic logic [15:0] pat(input logic [1:0] sel, input logic [15:0] seed,
                                        input int a);
        logic [15:0] ax;
        ax = 16'(a);
        case (sel)
            2'd0:    return ax;
            2'd1:    return seed;
            2'd2:    return seed ^ ax;
            default: return ax[0] ? ~seed : seed;
        endcase
    endfunction

    // Scoreboard of expected requests {wr, addr, wdata}; reads carry zero data.
    logic [20:0] sb_q [$];

    always @(negedge clk_i) begin
        if (!rst_i && mem_valid_o) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_req: got wr=%0d addr=%0h, expected no request",
                         mem_wr_rd_o, mem_addr_o);
            end else begin
                chk("req", {43'h0, mem_wr_rd_o, mem_addr_o, mem_wr_rd_o ? mem_wr_data_o : 16'h0},
                    {43'h0, sb_q.pop_front()});
            end
        end
    end

    task automatic push_reqs(input logic [1:0] sel, input logic [15:0] seed, input logic hold);
        int n_wr;
        n_wr = hold ? int'(HOLD_ADDR) + 1 : DEPTH;
        for (int a = 0; a < n_wr; a++) sb_q.push_back({1'b1, 4'(a), pat(sel, seed, a)});
        if (!hold)
            for (int a = 0; a < DEPTH; a++) sb_q.push_back({1'b0, 4'(a), 16'h0});
    endtask

    // Pulse start at the next posedge; returns at the negedge after that edge.
    task automatic do_start(input logic [1:0] sel, input logic [15:0] seed);
        @(negedge clk_i);
        pattern_sel_i = sel;
        seed_i = seed;
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        pattern_sel_i = ~sel;
        seed_i = ~seed;
    endtask

    typedef struct {
        logic [1:0]  sel;
        logic [15:0] seed;
        logic [15:0] fault_mask;
        logic        hold;
        int          exp_cyc;
        logic        exp_pass;
        logic        exp_to;
        logic [4:0]  exp_err;
        logic [3:0]  exp_faddr;
        logic [15:0] exp_fdata;
    } vec_t;

    vec_t vecs[6];

    task automatic check_done(input string tag, input int cyc, input vec_t v);
        chk({tag, "_cycles"},  64'(cyc), 64'(v.exp_cyc));
        chk({tag, "_pass"},    64'(pass_o), 64'(v.exp_pass));
        chk({tag, "_timeout"}, 64'(timeout_o), 64'(v.exp_to));
        chk({tag, "_err_cnt"}, 64'(err_cnt_o), 64'(v.exp_err));
        chk({tag, "_ferr"},    {44'h0, first_err_addr_o, first_err_data_o},
                               {44'h0, v.exp_faddr, v.exp_fdata});
        chk({tag, "_idle_bus"}, {62'h0, busy_o, mem_valid_o}, 64'h0);
        chk({tag, "_sb_left"}, 64'(sb_q.size()), 64'h0);
    endtask

    initial begin
        int cyc;
        vecs[0] = '{2'd0, 16'h0000, 16'h0000, 1'b0, 64, 1'b1, 1'b0, 5'd0,  4'd0, 16'h0000};
        vecs[1] = '{2'd3, 16'hA5A5, 16'h0000, 1'b0, 64, 1'b1, 1'b0, 5'd0,  4'd0, 16'h0000};
        vecs[2] = '{2'd1, 16'h00F0, 16'h0220, 1'b0, 64, 1'b0, 1'b0, 5'd2,  4'd5, 16'h00F1};
        vecs[3] = '{2'd0, 16'h0000, 16'h0000, 1'b1, 22, 1'b0, 1'b1, 5'd0,  4'd0, 16'h0000};
        vecs[4] = '{2'd2, 16'h1234, 16'h8001, 1'b0, 64, 1'b0, 1'b0, 5'd2,  4'd0, 16'h1235};
        vecs[5] = '{2'd3, 16'hFFFF, 16'hFFFF, 1'b0, 64, 1'b0, 1'b0, 5'd16, 4'd0, 16'hFFFE};

        repeat (3) @(negedge clk_i);
        chk("reset_outputs", {13'h0, busy_o, done_o, pass_o, timeout_o, err_cnt_o,
                              first_err_addr_o, first_err_data_o, mem_valid_o, mem_wr_rd_o,
                              mem_addr_o, mem_wr_data_o}, 64'h0);
        rst_i = 1'b0;

        for (int i = 0; i < 6; i++) begin
            fault_mask = vecs[i].fault_mask;
            hold_en = vecs[i].hold;
            push_reqs(vecs[i].sel, vecs[i].seed, vecs[i].hold);
            do_start(vecs[i].sel, vecs[i].seed);
            cyc = 0;
            while (!done_o && cyc < 300) begin
                @(negedge clk_i);
                cyc++;
            end
            check_done($sformatf("vec%0d", i), cyc, vecs[i]);
            if (i == 1) begin
                chk("cb_word0", 64'(mem_arr[0]), 64'h0000A5A5);
                chk("cb_word1", 64'(mem_arr[1]), 64'h00005A5A);
            end
        end
        hold_en = 1'b0;
        fault_mask = 16'h0;

        // Start re-pulsed mid-run must be ignored.
        push_reqs(2'd0, 16'h0, 1'b0);
        do_start(2'd0, 16'h0);
        cyc = 0;
        while (!done_o && cyc < 300) begin
            @(negedge clk_i);
            cyc++;
            start_i = (cyc == 10);
        end
        start_i = 1'b0;
        check_done("restart_ignored", cyc, vecs[0]);

        // Asynchronous reset mid-run, then a clean run.
        push_reqs(2'd2, 16'h0F0F, 1'b0);
        do_start(2'd2, 16'h0F0F);
        repeat (20) @(negedge clk_i);
        #2 rst_i = 1'b1;
        #1;
        chk("midreset_outputs", {13'h0, busy_o, done_o, pass_o, timeout_o, err_cnt_o,
                                 first_err_addr_o, first_err_data_o, mem_valid_o, mem_wr_rd_o,
                                 mem_addr_o, mem_wr_data_o}, 64'h0);
        sb_q.delete();
        @(negedge clk_i);
        rst_i = 1'b0;
        push_reqs(2'd2, 16'h0F0F, 1'b0);
        do_start(2'd2, 16'h0F0F);
        cyc = 0;
        while (!done_o && cyc < 300) begin
            @(negedge clk_i);
            cyc++;
        end
        check_done("post_reset", cyc, vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_pattern_checker.md
Name: mem_pattern_checker

Overview:
Bus master for the single-port valid/ready memory (registered one-cycle response). On start, it writes a selectable data pattern to every address, then reads every address back and compares the data. It reports pass/fail, the error count, the first failing address/data, and a response timeout. Used for power-on memory self-test and board bring-up. Sits directly upstream of the memory and drives its request port.

Parameters:
WIDTH, 16, memory data width
DEPTH, 16, number of words tested (addresses 0..DEPTH-1; DEPTH <= 2**ADDR_LINES)
ADDR_LINES, 4, memory address width
TIMEOUT, 15, max WAIT cycles without mem_ready_i before abort (>=1)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
start_i  in  1  start test; sampled only in IDLE/DONE
pattern_sel_i  in  2  0=address, 1=seed, 2=seed XOR address, 3=checkerboard
seed_i  in  WIDTH  pattern seed; latched at start
busy_o  out  1  test running
done_o  out  1  test finished; held until next start
pass_o  out  1  valid with done_o: no mismatch and no timeout
timeout_o  out  1  aborted on missing ready; valid with done_o
err_cnt_o  out  ADDR_LINES+1  number of mismatching reads, saturating at DEPTH
first_err_addr_o  out  ADDR_LINES  address of first mismatch
first_err_data_o  out  WIDTH  read data at first mismatch
mem_valid_o  out  1  request strobe to memory
mem_wr_rd_o  out  1  1=write, 0=read
mem_addr_o  out  ADDR_LINES  request address
mem_wr_data_o  out  WIDTH  write data
mem_ready_i  in  1  memory response (registered, one cycle after valid)
mem_rd_data_i  in  WIDTH  read data, valid when mem_ready_i=1 on a read

Behaviour:
- Reset: all outputs 0. State=IDLE, address counter=0, timeout counter=0.
- Pattern pat(a): 0 -> a zero-extended/truncated to WIDTH; 1 -> seed; 2 -> seed ^ a (a zero-extended); 3 -> seed if a[0]==0, else ~seed. pattern_sel_i and seed_i are latched at start and are ignored mid-test.
- States: IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, DONE.
- IDLE/DONE with start_i=1:
  - Latch pattern_sel_i and seed_i.
  - Clear done_o, pass_o, timeout_o, err_cnt_o, first_err_*.
  - Set addr=0, busy_o=1, go to WR_REQ.
- WR_REQ: mem_valid_o=1, mem_wr_rd_o=1, mem_addr_o=addr, mem_wr_data_o=pat(addr). Exactly one cycle, then WR_WAIT.
- WR_WAIT: mem_valid_o=0.
  - mem_ready_i=1 and addr==DEPTH-1: addr=0, go to RD_REQ.
  - mem_ready_i=1 otherwise: addr+1, go to WR_REQ.
- RD_REQ: mem_valid_o=1, mem_wr_rd_o=0, mem_addr_o=addr. One cycle, then RD_WAIT.
- RD_WAIT: on mem_ready_i=1, compare mem_rd_data_i with pat(addr).
  - On mismatch: err_cnt_o+1 (saturating). If this is the first mismatch, capture first_err_addr_o=addr and first_err_data_o=mem_rd_data_i.
  - Then advance addr, or at addr==DEPTH-1 go to DONE.
- Request/response timing:
  - Each request is a single-cycle valid pulse; valid is never held across the wait.
  - mem_ready_i is honoured only in WR_WAIT/RD_WAIT; at any other time it is ignored.
- DONE: busy_o=0, done_o=1, pass_o=(err_cnt==0 && !timeout). While in DONE, mem_valid_o=0.
- Timeout:
  - The counter clears in each REQ state and increments in each WAIT cycle with mem_ready_i=0.
  - When the counter reaches TIMEOUT, go to DONE with timeout_o=1 and pass_o=0; err_cnt_o and first_err_* keep their values.
- Latency with a 1-cycle memory: 2 cycles per transaction. done_o rises exactly 4*DEPTH cycles after the edge that samples start_i (64 at defaults).
- start_i while busy_o=1 is ignored. start_i in DONE restarts the test.
- Reset mid-test: immediate return to IDLE with all outputs 0; mem_valid_o drops asynchronously.
- Address counter never exceeds DEPTH-1, including when DEPTH < 2**ADDR_LINES.

Test Plan:
- Good memory, sel=0, start pulse: 16 writes with data=addr, then 16 reads. Expect done_o at +64 cycles, pass_o=1, err_cnt_o=0, timeout_o=0.
- sel=3, seed=16'hA5A5: writes alternate A5A5/5A5A by address. Readback expects pass_o=1. Check mem_wr_data_o at addr 1 = 16'h5A5A.
- Memory model flips bit 0 on reads of addresses 5 and 9, sel=1, seed=16'h00F0: expect err_cnt_o=2, first_err_addr_o=5, first_err_data_o=16'h00F1, pass_o=0.
- Memory model withholds ready after the write to addr 3: after 15 WAIT cycles expect done_o=1, timeout_o=1, pass_o=0, mem_valid_o=0.
- start_i re-pulsed at cycle 10 of a run: ignored, done_o still at +64. Then assert rst_i at cycle 20 of a new run: all outputs 0 immediately, and a subsequent start runs cleanly.
